// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: load/store size codes, the
// transaction state enum and the alignment/legality rule.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  // A halfword needs an even address and a word a 4-byte-aligned one.
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: access_ok = 1'b1;
      F3_H, F3_HU: access_ok = ~addr_lo[0];
      F3_W:        access_ok = (addr_lo == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data bus: store byte enables and replicated write
// data, and lane selection plus sign/zero extension of load data.
module mem_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = store_data_i;
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = rdata_i;

    // Store size comes from the low two funct3 bits only.
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase

    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data_o = {24'd0, shifted[7:0]};
      F3_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// Pipeline memory stage: passes ALU results through in one cycle and runs
// one data-bus transaction per load/store, stalling upstream meanwhile.
module stage_memory
  import core_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        execute_valid,
  input  logic [4:0]  execute_rd,
  input  logic        execute_wr_enable,
  input  logic        execute_mem_to_reg,
  input  logic        execute_mem_write,
  input  logic [2:0]  execute_funct3,
  input  logic [31:0] execute_alu_result,
  input  logic [31:0] execute_store_data,
  output logic        memory_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  memory_rd,
  output logic        memory_wr_enable,
  output logic [31:0] memory_result,
  output logic        memory_fault
);

  localparam int CW = 10;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RSP_TIMEOUT - 1);

  mem_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [4:0]    rd_q, rd_d;
  logic          wr_en_q, wr_en_d;
  logic          store_q, store_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    mrd_q, mrd_d;
  logic          mwe_q, mwe_d;
  logic [31:0]   mres_q, mres_d;
  logic          fault_q, fault_d;

  logic          is_mem, legal, in_req, load_we;
  logic [3:0]    be;
  logic [31:0]   wdata, load_data;

  mem_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  assign is_mem  = execute_mem_to_reg | execute_mem_write;
  assign legal   = access_ok(execute_funct3, execute_alu_result[1:0]);
  assign in_req  = (state_q == S_REQ);
  assign load_we = wr_en_q & (rd_q != 5'd0);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    rd_d         = rd_q;
    wr_en_d      = wr_en_q;
    store_d      = store_q;
    f3_d         = f3_q;
    cnt_d        = cnt_q;
    mrd_d        = mrd_q;
    mres_d       = mres_q;
    mwe_d        = 1'b0;
    fault_d      = 1'b0;
    memory_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (execute_valid && is_mem) begin
          mrd_d = execute_rd;
          if (legal) begin
            memory_stall = 1'b1;
            addr_d       = execute_alu_result;
            sdata_d      = execute_store_data;
            rd_d         = execute_rd;
            wr_en_d      = execute_wr_enable;
            store_d      = execute_mem_write;
            f3_d         = execute_funct3;
            state_d      = S_REQ;
          end else begin
            fault_d = 1'b1;
          end
        end else if (execute_valid) begin
          mrd_d  = execute_rd;
          mres_d = execute_alu_result;
          mwe_d  = execute_wr_enable & (execute_rd != 5'd0);
        end
      end
      S_REQ: begin
        memory_stall = 1'b1;
        if (dmem_gnt) begin
          cnt_d = '0;
          mrd_d = rd_q;
          if (store_q) begin
            state_d = S_DONE;
          end else if (dmem_rvalid) begin
            mres_d  = load_data;
            mwe_d   = load_we;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        memory_stall = 1'b1;
        // A response arriving on the last allowed cycle still wins over the abort.
        if (dmem_rvalid) begin
          mres_d  = load_data;
          mwe_d   = load_we;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      wr_en_q <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      cnt_q   <= '0;
      mrd_q   <= '0;
      mwe_q   <= 1'b0;
      mres_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rd_q    <= rd_d;
      wr_en_q <= wr_en_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      mrd_q   <= mrd_d;
      mwe_q   <= mwe_d;
      mres_q  <= mres_d;
      fault_q <= fault_d;
    end
  end

  assign dmem_req         = in_req;
  assign dmem_we          = in_req & store_q;
  assign dmem_addr        = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_be          = in_req ? be : 4'b0000;
  assign dmem_wdata       = in_req ? wdata : 32'd0;
  assign memory_rd        = mrd_q;
  assign memory_wr_enable = mwe_q;
  assign memory_result    = mres_q;
  assign memory_fault     = fault_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed bus scenarios plus random
// ALU and load/store traffic against a byte-level reference model.
module tb_stage_memory;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        execute_valid, execute_wr_enable, execute_mem_to_reg, execute_mem_write;
  logic [4:0]  execute_rd;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_alu_result, execute_store_data;
  logic        memory_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  memory_rd;
  logic        memory_wr_enable, memory_fault;
  logic [31:0] memory_result;

  int vectors = 0;
  int miscompares = 0;

  stage_memory #(.RSP_TIMEOUT(TMO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .execute_valid      (execute_valid),
    .execute_rd         (execute_rd),
    .execute_wr_enable  (execute_wr_enable),
    .execute_mem_to_reg (execute_mem_to_reg),
    .execute_mem_write  (execute_mem_write),
    .execute_funct3     (execute_funct3),
    .execute_alu_result (execute_alu_result),
    .execute_store_data (execute_store_data),
    .memory_stall       (memory_stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_gnt           (dmem_gnt),
    .dmem_rvalid        (dmem_rvalid),
    .dmem_rdata         (dmem_rdata),
    .memory_rd          (memory_rd),
    .memory_wr_enable   (memory_wr_enable),
    .memory_result      (memory_result),
    .memory_fault       (memory_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_m(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal_m(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = size_m(f3);
    return (n != 0) && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] be_m(input logic [2:0] f3, input logic [31:0] addr);
    int n, ofs;
    n = size_m(f3);
    ofs = addr % 4;
    return 4'(((1 << n) - 1) << ofs);
  endfunction

  function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int n;
    n = size_m(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = data[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint v;
    int n, ofs;
    n = size_m(f3);
    ofs = addr % 4;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(rdata[8*(ofs+i) +: 8]) << (8*i);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8*n - 1)))
      v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---------------- stimulus driver (observes, does not judge) ----------------
  // gnt_wait: REQ cycles before the grant. rsp_wait: -1 = rvalid with the
  // grant, otherwise number of WAIT cycles without rvalid before it arrives.
  task automatic run_mem(
      input  bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
      input  logic [4:0] rd, input bit wr, input int gnt_wait, input int rsp_wait,
      input  logic [31:0] rdata,
      output bit o_done, output int o_stall, output int o_req,
      output logic [31:0] o_addr, output logic [3:0] o_be, output logic [31:0] o_wdata,
      output logic o_we_bus, output bit o_stable,
      output logic [31:0] o_res, output logic o_mwe, output logic [4:0] o_mrd,
      output logic o_fault, output logic o_mwe_after, output logic o_fault_after);
    bit granted;
    int wait_n;
    granted = 0; wait_n = 0; o_done = 0; o_stall = 0; o_req = 0; o_stable = 1;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we_bus = 0;
    o_res = '0; o_mwe = 0; o_mrd = '0; o_fault = 0; o_mwe_after = 0; o_fault_after = 0;
    execute_valid = 1; execute_rd = rd; execute_wr_enable = wr;
    execute_mem_to_reg = !st; execute_mem_write = st; execute_funct3 = f3;
    execute_alu_result = addr; execute_store_data = data;
    for (int k = 0; k < 64 && !o_done; k++) begin
      #1;
      if (memory_stall) o_stall++;
      dmem_gnt = 0; dmem_rvalid = 0;
      if (dmem_req) begin
        if (o_req == 0) begin
          o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we_bus = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {o_addr, o_be, o_wdata, o_we_bus}) begin
          o_stable = 0;
        end
        if (o_req == gnt_wait) begin
          dmem_gnt = 1; granted = 1;
          if (!st && rsp_wait < 0) begin dmem_rvalid = 1; dmem_rdata = rdata; end
        end
        o_req++;
      end else if (granted && !st) begin
        if (wait_n == rsp_wait) begin dmem_rvalid = 1; dmem_rdata = rdata; end
        wait_n++;
      end
      @(posedge clk); #1;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
      if (!memory_stall) begin
        o_done = 1;
        o_res = memory_result; o_mwe = memory_wr_enable; o_mrd = memory_rd; o_fault = memory_fault;
      end
    end
    execute_valid = 0; execute_mem_to_reg = 0; execute_mem_write = 0;
    @(posedge clk); #1;
    o_mwe_after = memory_wr_enable; o_fault_after = memory_fault;
  endtask

  // shared result holders for the test tasks
  bit          r_done, r_stable;
  int          r_stall, r_req;
  logic [31:0] r_addr, r_wdata, r_res;
  logic [3:0]  r_be;
  logic        r_we_bus, r_mwe, r_fault, r_mwe_after, r_fault_after;
  logic [4:0]  r_mrd;

  task automatic idle_inputs();
    execute_valid = 0; execute_rd = 0; execute_wr_enable = 0; execute_mem_to_reg = 0;
    execute_mem_write = 0; execute_funct3 = 0; execute_alu_result = 0; execute_store_data = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({dmem_req, dmem_we, memory_stall, memory_fault, memory_wr_enable} !== 5'b0 ||
        memory_rd !== 5'd0 || memory_result !== 32'd0 || dmem_be !== 4'd0 || dmem_addr !== 32'd0)
      begin miscompares++;
        $display("FAIL reset: req=%b stall=%b fault=%b we=%b rd=%0d res=%h be=%b addr=%h, need all 0",
                 dmem_req, memory_stall, memory_fault, memory_wr_enable, memory_rd, memory_result, dmem_be, dmem_addr);
      end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_basic();
    run_mem(0, 3'b010, 32'h100, 32'h0, 5'd3, 1, 0, 1, 32'hDEADBEEF,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (!r_done || r_res !== 32'hDEADBEEF || r_mwe !== 1'b1 || r_mrd !== 5'd3) begin miscompares++;
      $display("FAIL lw_result: done=%0d res=%h we=%b rd=%0d, need 1 deadbeef 1 3", r_done, r_res, r_mwe, r_mrd); end
    vectors++;
    if (r_stall != 4 || r_req != 1 || r_addr !== 32'h100 || r_be !== 4'hF || r_we_bus !== 1'b0) begin miscompares++;
      $display("FAIL lw_timing: stall=%0d req=%0d addr=%h be=%b we=%b, need 4 1 100 1111 0", r_stall, r_req, r_addr, r_be, r_we_bus); end
    vectors++;
    if (r_mwe_after !== 1'b0 || r_fault !== 1'b0) begin miscompares++;
      $display("FAIL lw_pulse: we_after=%b fault=%b, need 0 0", r_mwe_after, r_fault); end
  endtask

  task automatic test_lb_lbu();
    run_mem(0, 3'b000, 32'h103, 32'h0, 5'd9, 1, 1, -1, 32'h80000000,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (r_res !== 32'hFFFFFF80 || r_mwe !== 1'b1 || r_addr !== 32'h100 || r_be !== 4'b1000 || !r_stable) begin miscompares++;
      $display("FAIL lb: res=%h we=%b addr=%h be=%b stable=%0d, need ffffff80 1 100 1000 1", r_res, r_mwe, r_addr, r_be, r_stable); end
    run_mem(0, 3'b100, 32'h103, 32'h0, 5'd9, 1, 0, 0, 32'h80000000,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (r_res !== 32'h00000080 || r_mwe !== 1'b1) begin miscompares++;
      $display("FAIL lbu: res=%h we=%b, need 00000080 1", r_res, r_mwe); end
  endtask

  task automatic test_sh();
    run_mem(1, 3'b001, 32'h202, 32'h1234, 5'd4, 0, 2, 0, 32'h0,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (r_be !== 4'b1100 || r_wdata !== 32'h12341234 || r_addr !== 32'h200 || r_we_bus !== 1'b1) begin miscompares++;
      $display("FAIL sh_bus: be=%b wdata=%h addr=%h we=%b, need 1100 12341234 200 1", r_be, r_wdata, r_addr, r_we_bus); end
    vectors++;
    if (r_mwe !== 1'b0 || r_req != 3 || !r_stable || r_stall != 4) begin miscompares++;
      $display("FAIL sh_ctrl: wr_en=%b req=%0d stable=%0d stall=%0d, need 0 3 1 4", r_mwe, r_req, r_stable, r_stall); end
  endtask

  task automatic test_misaligned();
    run_mem(0, 3'b010, 32'h101, 32'h0, 5'd5, 1, 0, 0, 32'h0,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (r_req != 0 || r_stall != 0 || r_fault !== 1'b1 || r_mwe !== 1'b0 || r_fault_after !== 1'b0) begin miscompares++;
      $display("FAIL misaligned: req=%0d stall=%0d fault=%b we=%b fault_after=%b, need 0 0 1 0 0",
               r_req, r_stall, r_fault, r_mwe, r_fault_after); end
  endtask

  task automatic test_timeout();
    run_mem(0, 3'b010, 32'h400, 32'h0, 5'd6, 1, 0, 1000, 32'h0,
            r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
            r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
    vectors++;
    if (!r_done || r_stall != 2 + TMO || r_fault !== 1'b1 || r_mwe !== 1'b0 || r_fault_after !== 1'b0) begin miscompares++;
      $display("FAIL timeout: done=%0d stall=%0d fault=%b we=%b fault_after=%b, need 1 %0d 1 0 0",
               r_done, r_stall, r_fault, r_mwe, r_fault_after, 2 + TMO); end
    vectors++;
    if (memory_stall !== 1'b0 || dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL timeout_idle: stall=%b req=%b, need 0 0", memory_stall, dmem_req); end
  endtask

  task automatic test_reset_in_wait();
    execute_valid = 1; execute_rd = 5'd7; execute_wr_enable = 1; execute_mem_to_reg = 1;
    execute_mem_write = 0; execute_funct3 = 3'b010; execute_alu_result = 32'h300;
    @(posedge clk); #1;
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    @(posedge clk); #1;
    vectors++;
    if (memory_stall !== 1'b1 || dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL wait_entry: stall=%b req=%b, need 1 0", memory_stall, dmem_req); end
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_rvalid = 0;
    @(posedge clk); #1;
    vectors++;
    if (memory_wr_enable !== 1'b0 || memory_result !== 32'd0 || memory_rd !== 5'd0 ||
        memory_fault !== 1'b0 || memory_stall !== 1'b0 || dmem_req !== 1'b0) begin miscompares++;
      $display("FAIL reset_in_wait: we=%b res=%h rd=%0d fault=%b stall=%b req=%b, need all 0",
               memory_wr_enable, memory_result, memory_rd, memory_fault, memory_stall, dmem_req); end
  endtask

  task automatic test_alu_random();
    logic v, we;
    logic [4:0] rd;
    logic [31:0] res;
    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 3) != 0); we = $urandom; rd = $urandom; res = $urandom;
      if (i == 0) rd = 5'd0;
      execute_valid = v; execute_rd = rd; execute_wr_enable = we; execute_mem_to_reg = 0;
      execute_mem_write = 0; execute_funct3 = $urandom; execute_alu_result = res;
      dmem_gnt = $urandom; dmem_rvalid = $urandom; dmem_rdata = $urandom;
      #1;
      vectors++;
      if (memory_stall !== 1'b0 || dmem_req !== 1'b0) begin miscompares++;
        $display("FAIL alu_nostall[%0d]: stall=%b req=%b, need 0 0", i, memory_stall, dmem_req); end
      @(posedge clk); #1;
      vectors++;
      if (memory_wr_enable !== (v && we && rd != 5'd0)) begin miscompares++;
        $display("FAIL alu_we[%0d]: got %b need %b", i, memory_wr_enable, (v && we && rd != 5'd0)); end
      if (v) begin
        vectors++;
        if (memory_rd !== rd || memory_result !== res) begin miscompares++;
          $display("FAIL alu_payload[%0d]: rd=%0d res=%h need %0d %h", i, memory_rd, memory_result, rd, res); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mem_random();
    bit st, wr;
    logic [2:0] f3;
    logic [31:0] addr, data, rdata;
    logic [4:0] rd;
    int gw, rw, exp_stall;
    for (int i = 0; i < 60; i++) begin
      st = $urandom; wr = $urandom; f3 = $urandom; rd = $urandom;
      addr = $urandom; data = $urandom; rdata = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      gw = $urandom_range(0, 2); rw = $urandom_range(0, 4) - 1;
      run_mem(st, f3, addr, data, rd, wr, gw, rw, rdata,
              r_done, r_stall, r_req, r_addr, r_be, r_wdata, r_we_bus, r_stable,
              r_res, r_mwe, r_mrd, r_fault, r_mwe_after, r_fault_after);
      vectors++;
      if (!r_done) begin miscompares++;
        $display("FAIL rnd_hang[%0d]: transaction did not complete within budget", i); end
      if (!legal_m(f3, addr)) begin
        vectors++;
        if (r_req != 0 || r_stall != 0 || r_fault !== 1'b1 || r_mwe !== 1'b0 || r_fault_after !== 1'b0) begin miscompares++;
          $display("FAIL rnd_illegal[%0d] f3=%b addr=%h: req=%0d stall=%0d fault=%b we=%b, need 0 0 1 0",
                   i, f3, addr, r_req, r_stall, r_fault, r_mwe); end
      end else begin
        exp_stall = 2 + gw + ((st || rw < 0) ? 0 : rw + 1);
        vectors++;
        if (r_req != gw + 1 || r_stall != exp_stall || !r_stable || r_fault !== 1'b0 ||
            r_addr !== {addr[31:2], 2'b00} || r_be !== be_m(f3, addr) || r_we_bus !== st) begin miscompares++;
          $display("FAIL rnd_bus[%0d] f3=%b addr=%h: req=%0d stall=%0d stable=%0d fault=%b a=%h be=%b we=%b, need %0d %0d 1 0 %h %b %b",
                   i, f3, addr, r_req, r_stall, r_stable, r_fault, r_addr, r_be, r_we_bus,
                   gw + 1, exp_stall, {addr[31:2], 2'b00}, be_m(f3, addr), st); end
        if (st) begin
          vectors++;
          if (r_wdata !== wdata_m(f3, data) || r_mwe !== 1'b0) begin miscompares++;
            $display("FAIL rnd_store[%0d] f3=%b: wdata=%h we=%b, need %h 0", i, f3, r_wdata, r_mwe, wdata_m(f3, data)); end
        end else begin
          vectors++;
          if (r_res !== load_m(f3, addr, rdata) || r_mwe !== (wr && rd != 5'd0) || r_mrd !== rd) begin miscompares++;
            $display("FAIL rnd_load[%0d] f3=%b addr=%h rdata=%h: res=%h we=%b rd=%0d, need %h %b %0d",
                     i, f3, addr, rdata, r_res, r_mwe, r_mrd, load_m(f3, addr, rdata), (wr && rd != 5'd0), rd); end
        end
        vectors++;
        if (r_mwe_after !== 1'b0 || r_fault_after !== 1'b0) begin miscompares++;
          $display("FAIL rnd_oneshot[%0d]: we_after=%b fault_after=%b, need 0 0", i, r_mwe_after, r_fault_after); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_alu_random();
    test_mem_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
